// File: rtl/s2p_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : s2p_pkg
//  Purpose  : Shared types and constants for the serial-to-parallel converter.
//  Revision : 1.0
// ============================================================================
package s2p_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } s2p_state_e;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s2p_deserializer_out_stage.sv
`default_nettype none
// ============================================================================
//  Module   : s2p_out_stage
//  Purpose  : Holding register, valid/ready handshake, parity flag, overrun.
//  Revision : 1.0
// ============================================================================
module s2p_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_parity_err,
    input  logic             i_ready,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_parity_err,
    output logic             o_overrun
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;

        // Overrun clears only when realigning with nothing pending; the set
        // below needs valid_q=1, so the two never collide.
        if (i_sync && !valid_q) begin
            ovr_d = 1'b0;
        end

        if (i_load) begin
            word_d  = i_word;
            perr_d  = i_parity_err;
            valid_d = 1'b1;
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_word       = word_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_overrun    = ovr_q;

endmodule
`default_nettype wire

// File: rtl/s2p_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : s2p_deserializer
//  Purpose  : Parametrised serial-to-parallel converter with optional parity.
//  Revision : 1.0
// ============================================================================
module s2p_deserializer
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             sync,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int              CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("s2p_deserializer: WIDTH out of range");
        end
    endgenerate

    s2p_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             busy_q, busy_d;

    s2p_state_e       w_base_state;
    logic [CNT_W-1:0] w_base_cnt;
    logic [WIDTH-1:0] w_base_shift;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
    logic             w_par_bit;
    logic             w_perr;

    // sync acts first so a bit sampled in the same cycle starts a fresh frame.
    assign w_base_state = sync ? ST_IDLE : state_q;
    assign w_base_cnt   = sync ? '0 : bit_cnt_q;
    assign w_base_shift = sync ? '0 : shift_q;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {w_base_shift[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shifted = {serial_in, w_base_shift[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = w_base_state;
        bit_cnt_d = w_base_cnt;
        shift_d   = w_base_shift;
        w_load    = 1'b0;
        w_word    = w_shifted;
        w_par_bit = 1'b0;

        if (bit_en) begin
            if (w_base_state == ST_PAR) begin
                w_load    = 1'b1;
                w_word    = w_base_shift;
                w_par_bit = serial_in;
                state_d   = ST_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else begin
                shift_d = w_shifted;
                if (w_base_cnt == CNT_LAST) begin
                    bit_cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = ST_PAR;
                    end else begin
                        state_d = ST_IDLE;
                        w_load  = 1'b1;
                        shift_d = '0;
                    end
                end else begin
                    bit_cnt_d = w_base_cnt + 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign w_perr = (PARITY_EN != 0) ? ((^w_word) ^ w_par_bit) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;

    s2p_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_word       (w_word),
        .i_parity_err (w_perr),
        .i_ready      (out_ready),
        .i_sync       (sync),
        .o_word       (par_out),
        .o_valid      (out_valid),
        .o_parity_err (parity_err),
        .o_overrun    (overrun)
    );

endmodule
`default_nettype wire
